nios_pio_in_debounced: RTL
==========================

# nios_pio_in_debounced

Parametrised Avalon-MM input PIO for the Nios II system, successor to the single-bit input ports used for the coffee-machine buttons. Samples `WIDTH` asynchronous inputs through a synchronizer, debounces each channel independently, and exposes level, raw, interrupt-mask and edge-capture registers. Drives one level-sensitive IRQ toward the Nios II interrupt controller. Sits between board pushbuttons/switches and the Avalon interconnect.

## Interface
- `WIDTH`, 4: number of input channels, 1..32
- `DEBOUNCE_CYCLES`, 50000: stable cycles required before a level change is accepted, ≥1
- `SYNC_STAGES`, 2: synchronizer flops per channel, ≥2
- `EDGE_TYPE`, 0: 0 rising, 1 falling, 2 any edge
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `address`  in  2  register select
- `chipselect`  in  1  slave select
- `write`  in  1  write strobe, qualified by `chipselect`
- `writedata`  in  32  write data
- `in_port`  in  WIDTH  asynchronous board inputs
- `readdata`  out  32  registered read data
- `irq`  out  1  interrupt request, active high

## Operation
- Register map, all bits above `WIDTH` read 0, writes ignored:
  - 0 DATA (RO): debounced levels
  - 1 RAW (RO): synchronizer outputs, not debounced
  - 2 IRQMASK (RW): per-channel interrupt enable
  - 3 EDGECAP (W1C): sticky edge flags; writing 1 clears that bit, writing 0 has no effect
- Writes occur when `chipselect & write`; writes to 0/1 are ignored.
- Per-channel debounce: counter resets to 0 whenever sync == debounced; otherwise increments; when it equals `DEBOUNCE_CYCLES-1` while still differing, debounced <= sync and counter <= 0. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches DATA.
- Counter width `$clog2(DEBOUNCE_CYCLES+1)`; no wrap possible (cleared at terminal value).
- Edge detect on debounced value vs. its one-cycle-delayed copy, qualified by `EDGE_TYPE`; sets EDGECAP bit.
- Same-cycle edge set and W1C clear on one bit: set wins.
- `irq` = OR of (EDGECAP & IRQMASK); stays high until software clears flags or mask.

## Timing
- Reset: synchronizers, debounced levels, delay copies, counters, IRQMASK, EDGECAP, `readdata` all 0; `irq` 0.
- Input change stable from cycle 0 → RAW reflects it after `SYNC_STAGES` cycles → DATA changes `SYNC_STAGES + DEBOUNCE_CYCLES` cycles after input change.
- EDGECAP bit sets one cycle after DATA changes; `irq` rises the same cycle (combinational from registers, no further flop).
- `readdata` updated every cycle from `address` regardless of `read`/`chipselect`; one-cycle read latency; reflects register contents before any write in the same cycle.
- Written IRQMASK/EDGECAP visible on `readdata` two cycles after the write cycle (register update, then readdata capture).
- Reset asserted mid-debounce discards the pending count; after release an input already held high needs the full latency again.

## Structure
- Shared package: register address constants (DATA, RAW, IRQMASK, EDGECAP) and `EDGE_TYPE` encodings.
- One sub-module `nios_pio_debounce`: single channel synchronizer + counter + debounced flop, instantiated `WIDTH` times via generate; top holds register file, edge logic, read mux.

## Test plan
- Reset: with `in_port`=4'hF held, assert `reset` → `readdata`=0, `irq`=0; all four registers read 0 except RAW=4'hF after `SYNC_STAGES` cycles.
- Debounce (`DEBOUNCE_CYCLES`=8, `SYNC_STAGES`=2): raise `in_port[0]` for 7 cycles then drop → DATA stays 0, EDGECAP 0; hold for ≥8 → DATA bit 0 = 1 exactly 10 cycles after the rise.
- Edge/IRQ (`EDGE_TYPE`=0): IRQMASK=4'b0010, debounced rise on channel 1 → EDGECAP=4'b0010, `irq`=1; write EDGECAP=4'b0010 → bit clears, `irq`=0 next cycle.
- Masking: rise on channel 2 with IRQMASK=0 → EDGECAP=4'b0100, `irq`=0; write IRQMASK=4'b0100 → `irq`=1 without new edge.
- Collision: W1C of bit 3 in the same cycle as a new channel-3 edge → bit 3 remains 1.
- `EDGE_TYPE`=1 and 2: falling-only sets on high→low only; any-edge sets on both; write 0 to EDGECAP changes nothing; writes to address 0/1 leave DATA/RAW unchanged.

Source files
------------

// File: rtl/nios_pio_in_debounced_pkg.sv
// Shared definitions for the debounced input PIO: register map and edge-type encodings.
package nios_pio_in_debounced_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_RAW     = 2'd1,
    REG_IRQMASK = 2'd2,
    REG_EDGECAP = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_pio_debounce.sv
// One input channel: metastability synchronizer, stability counter and debounced level flop.
module nios_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic sync_bit,
  output logic deb_bit
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   deb_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_bit};
    end
  end

  assign sync_bit = sync_reg[SYNC_STAGES-1];

  // Counter only runs while the synchronized input disagrees with the accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
      deb_reg <= 1'b0;
    end else if (sync_bit == deb_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
      deb_reg <= sync_bit;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign deb_bit = deb_reg;

endmodule

// File: rtl/nios_pio_in_debounced.sv
// Avalon-MM input PIO with per-channel debounce, interrupt mask, sticky edge capture and level IRQ.
module nios_pio_in_debounced
  import nios_pio_in_debounced_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] raw_vec;
  logic [WIDTH-1:0] deb_vec;
  logic [WIDTH-1:0] deb_dly_reg;
  logic [WIDTH-1:0] irqmask_reg;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edgecap_next;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] w1c_mask;
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;
  logic             wr_en;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    nios_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .in_bit  (in_port[gi]),
      .sync_bit(raw_vec[gi]),
      .deb_bit (deb_vec[gi])
    );
  end

  assign wr_en = chipselect & write;

  always_comb begin
    edge_hit = deb_vec & ~deb_dly_reg;
    if (EDGE_TYPE == EDGE_FALLING) begin
      edge_hit = ~deb_vec & deb_dly_reg;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_hit = deb_vec ^ deb_dly_reg;
    end
  end

  // A new edge in the same cycle as a W1C on that bit keeps the flag set.
  always_comb begin
    w1c_mask = '0;
    if (wr_en && address == REG_EDGECAP) begin
      w1c_mask = writedata[WIDTH-1:0];
    end
    edgecap_next = (edgecap_reg & ~w1c_mask) | edge_hit;
  end

  always_comb begin
    readdata_next = '0;
    case (reg_addr_e'(address))
      REG_DATA:    readdata_next[WIDTH-1:0] = deb_vec;
      REG_RAW:     readdata_next[WIDTH-1:0] = raw_vec;
      REG_IRQMASK: readdata_next[WIDTH-1:0] = irqmask_reg;
      REG_EDGECAP: readdata_next[WIDTH-1:0] = edgecap_reg;
      default:     readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_dly_reg  <= '0;
      irqmask_reg  <= '0;
      edgecap_reg  <= '0;
      readdata_reg <= '0;
    end else begin
      deb_dly_reg  <= deb_vec;
      edgecap_reg  <= edgecap_next;
      readdata_reg <= readdata_next;
      if (wr_en && address == REG_IRQMASK) begin
        irqmask_reg <= writedata[WIDTH-1:0];
      end
    end
  end

  assign readdata = readdata_reg;
  assign irq      = |(edgecap_reg & irqmask_reg);

endmodule
